// File: rtl/video_tmds_encode_pkg.sv
// Shared types, TMDS control tokens and helpers for the TMDS output stage.
package video_tmds_encode_pkg;

    localparam int unsigned COMP_W = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned SYM_W  = 10;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned POP_W  = 4;

    // Blended pixel from the playfield stage: {R[11:8], G[7:4], B[3:0]}
    typedef struct packed {
        logic [COMP_W-1:0] r;
        logic [COMP_W-1:0] g;
        logic [COMP_W-1:0] b;
    } rgb_t;

    typedef logic [SYM_W-1:0] tmds_t;

    localparam tmds_t TMDS_CTRL_00 = 10'b1101010100;
    localparam tmds_t TMDS_CTRL_01 = 10'b0010101011;
    localparam tmds_t TMDS_CTRL_10 = 10'b0101010100;
    localparam tmds_t TMDS_CTRL_11 = 10'b1010101011;

    // Number of set bits in a byte (0..8)
    function automatic logic [POP_W-1:0] popcount8(input logic [BYTE_W-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(BYTE_W); i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

    // Control token for {C1,C0}
    function automatic tmds_t ctrl_token(input logic [1:0] c);
        tmds_t t;
        case (c)
            2'b01:   t = TMDS_CTRL_01;
            2'b10:   t = TMDS_CTRL_10;
            2'b11:   t = TMDS_CTRL_11;
            default: t = TMDS_CTRL_00;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/video_tmds_encode_if.sv
// Pixel/sync bus from the blend stage and TMDS symbol bus toward the serialiser.
interface video_tmds_encode_if;
    import video_tmds_encode_pkg::*;

    rgb_t  rgb_i;
    logic  hsync_i;
    logic  vsync_i;
    logic  dv_de_i;
    tmds_t tmds_r_o;
    tmds_t tmds_g_o;
    tmds_t tmds_b_o;
    logic  hsync_o;
    logic  vsync_o;
    logic  dv_de_o;

    modport master (
        output rgb_i, hsync_i, vsync_i, dv_de_i,
        input  tmds_r_o, tmds_g_o, tmds_b_o, hsync_o, vsync_o, dv_de_o
    );

    modport slave (
        input  rgb_i, hsync_i, vsync_i, dv_de_i,
        output tmds_r_o, tmds_g_o, tmds_b_o, hsync_o, vsync_o, dv_de_o
    );

endinterface

// File: rtl/video_tmds_encode_chan.sv
// One TMDS channel: 4-bit expand, transition-minimise, DC-balance, control tokens.
module video_tmds_encode_chan
    import video_tmds_encode_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [COMP_W-1:0] comp,
    input  logic [1:0]        ctrl,
    input  logic              de,
    output tmds_t             sym
);

    localparam logic signed [CNT_W-1:0] CNT_TWO   = 6'sd2;
    localparam logic signed [CNT_W-1:0] CNT_EIGHT = 6'sd8;
    localparam logic signed [CNT_W-1:0] CNT_ZERO  = 6'sd0;

    logic [BYTE_W-1:0] d;
    logic [POP_W-1:0]  n1d;
    logic              use_xnor;
    logic [BYTE_W:0]   qm_c;

    logic [BYTE_W:0]   qm_q;
    logic [POP_W-1:0]  n1q_q;
    logic              de_q;
    logic [1:0]        ctrl_q;

    logic signed [CNT_W-1:0] cnt_q;
    logic signed [CNT_W-1:0] cnt_d;
    logic signed [CNT_W-1:0] diff;
    tmds_t                   sym_d;
    logic                    q8;
    logic [BYTE_W-1:0]       q;

    // Stage-1 combinational: nibble expansion and XOR/XNOR transition coding
    always_comb begin
        d        = {comp, comp};
        n1d      = popcount8(d);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
        qm_c     = '0;
        qm_c[0]  = d[0];
        for (int i = 1; i < int'(BYTE_W); i++) begin
            qm_c[i] = use_xnor ? ~(qm_c[i-1] ^ d[i]) : (qm_c[i-1] ^ d[i]);
        end
        qm_c[BYTE_W] = ~use_xnor;
    end

    // Stage-1 registers: coded byte, its ones count, DE and control bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            qm_q   <= '0;
            n1q_q  <= '0;
            de_q   <= 1'b0;
            ctrl_q <= 2'b00;
        end else begin
            qm_q   <= qm_c;
            n1q_q  <= popcount8(qm_c[BYTE_W-1:0]);
            de_q   <= de;
            ctrl_q <= ctrl;
        end
    end

    assign q8 = qm_q[BYTE_W];
    assign q  = qm_q[BYTE_W-1:0];

    // n1q - n0q = 2*n1q - 8, range -8..+8
    assign diff = $signed(CNT_W'({n1q_q, 1'b0})) - CNT_EIGHT;

    // Stage-2 combinational: DC balancing against the running disparity
    always_comb begin
        sym_d = ctrl_token(ctrl_q);
        cnt_d = CNT_ZERO;
        if (de_q) begin
            if ((cnt_q == CNT_ZERO) || (n1q_q == 4'd4)) begin
                sym_d = {~q8, q8, (q8 ? q : ~q)};
                cnt_d = q8 ? (cnt_q + diff) : (cnt_q - diff);
            end else if (((cnt_q > CNT_ZERO) && (n1q_q > 4'd4)) ||
                         ((cnt_q < CNT_ZERO) && (n1q_q < 4'd4))) begin
                sym_d = {1'b1, q8, ~q};
                cnt_d = cnt_q + (q8 ? CNT_TWO : CNT_ZERO) - diff;
            end else begin
                sym_d = {1'b0, q8, q};
                cnt_d = cnt_q - (q8 ? CNT_ZERO : CNT_TWO) + diff;
            end
        end
    end

    // Stage-2 registers: output symbol and running disparity
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sym   <= TMDS_CTRL_00;
            cnt_q <= CNT_ZERO;
        end else begin
            sym   <= sym_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/video_tmds_encode.sv
// DVI TMDS output stage: three channel encoders plus matched sync/DE delay.
module video_tmds_encode
    import video_tmds_encode_pkg::*;
#(
    parameter bit SYNC_INVERT = 1'b0,
    parameter bit EN_DE_OUT   = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    video_tmds_encode_if.slave  bus
);

    logic       hsync_pol_c;
    logic       vsync_pol_c;
    logic [1:0] blue_ctrl_c;

    assign hsync_pol_c = bus.hsync_i ^ SYNC_INVERT;
    assign vsync_pol_c = bus.vsync_i ^ SYNC_INVERT;
    assign blue_ctrl_c = {vsync_pol_c, hsync_pol_c};

    video_tmds_encode_chan u_chan_r (
        .clk     (clk),
        .reset_n (reset_n),
        .comp    (bus.rgb_i.r),
        .ctrl    (2'b00),
        .de      (bus.dv_de_i),
        .sym     (bus.tmds_r_o)
    );

    video_tmds_encode_chan u_chan_g (
        .clk     (clk),
        .reset_n (reset_n),
        .comp    (bus.rgb_i.g),
        .ctrl    (2'b00),
        .de      (bus.dv_de_i),
        .sym     (bus.tmds_g_o)
    );

    video_tmds_encode_chan u_chan_b (
        .clk     (clk),
        .reset_n (reset_n),
        .comp    (bus.rgb_i.b),
        .ctrl    (blue_ctrl_c),
        .de      (bus.dv_de_i),
        .sym     (bus.tmds_b_o)
    );

    if (EN_DE_OUT) begin : g_sync_out
        logic [2:0] sync_s1;
        logic [2:0] sync_s2;

        // Two-deep delay of {vsync, hsync, de} to line up with the symbols
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync_s1 <= '0;
                sync_s2 <= '0;
            end else begin
                sync_s1 <= {bus.vsync_i, bus.hsync_i, bus.dv_de_i};
                sync_s2 <= sync_s1;
            end
        end

        assign bus.vsync_o = sync_s2[2];
        assign bus.hsync_o = sync_s2[1];
        assign bus.dv_de_o = sync_s2[0];
    end else begin : g_sync_tie
        assign bus.vsync_o = 1'b0;
        assign bus.hsync_o = 1'b0;
        assign bus.dv_de_o = 1'b0;
    end

endmodule
